// File: rtl/ps2_key_event_fifo.sv
// PS/2 Set-2 scan-code parser: folds E0/F0 prefixes into key events, filters typematic
// repeats, attaches an ASCII value and queues the events in a first-word fall-through FIFO.
module ps2_key_event_fifo #(
  parameter int DEPTH           = 8,
  parameter int TIMEOUT_CYCLES  = 50000000,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               ps2_key_data,
  input  logic                     ps2_key_pressed,
  input  logic                     ev_ready,
  input  logic                     overflow_clr,
  output logic                     ev_valid,
  output logic [7:0]               ev_code,
  output logic                     ev_ext,
  output logic                     ev_release,
  output logic [7:0]               ev_ascii,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic ext);
    logic [7:0] a;
    a = 8'h00;
    if (!ext) begin
      case (code)
        8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
        8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
        8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
        8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
        8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
        8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
        8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
        8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
        8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
        8'h3E: a = 8'h38; 8'h46: a = 8'h39;
        8'h29: a = 8'h20; 8'h5A: a = 8'h0D;
        default: a = 8'h00;
      endcase
    end
    return a;
  endfunction

  state_t          state_p0, state_nxt;
  logic [TW-1:0]   tmo_cnt_p0;
  logic            ev_fire, ev_ext_n, ev_rel_n;

  // Stage 0: prefix parser
  always_comb begin
    state_nxt = state_p0;
    ev_fire   = 1'b0;
    ev_ext_n  = 1'b0;
    ev_rel_n  = 1'b0;
    if (ps2_key_pressed) begin
      case (ps2_key_data)
        8'hE0: state_nxt = EXT;
        8'hF0: begin
          if (state_p0 == IDLE)     state_nxt = BRK;
          else if (state_p0 == EXT) state_nxt = EXT_BRK;
        end
        8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: state_nxt = IDLE;
        default: begin
          ev_fire   = 1'b1;
          ev_ext_n  = (state_p0 == EXT) || (state_p0 == EXT_BRK);
          ev_rel_n  = (state_p0 == BRK) || (state_p0 == EXT_BRK);
          state_nxt = IDLE;
        end
      endcase
    end else if (state_p0 != IDLE && tmo_cnt_p0 == TW'(TIMEOUT_CYCLES - 1)) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_p0   <= IDLE;
      tmo_cnt_p0 <= '0;
    end else begin
      state_p0   <= state_nxt;
      tmo_cnt_p0 <= (ps2_key_pressed || state_nxt == IDLE) ? '0 : tmo_cnt_p0 + 1'b1;
    end
  end

  // Stage 1: repeat filter and FIFO write
  logic            held_vld_p0;
  logic [8:0]      held_key_p0;
  logic [8:0]      key_n;
  logic            held_match, is_repeat, push_req;

  assign key_n      = {ev_ext_n, ps2_key_data};
  assign held_match = held_vld_p0 && (held_key_p0 == key_n);
  assign is_repeat  = (SUPPRESS_REPEAT != 1'b0) && !ev_rel_n && held_match;
  assign push_req   = ev_fire && !is_repeat;

  always_ff @(posedge clock) begin
    if (reset) begin
      held_vld_p0 <= 1'b0;
    end else if (ev_fire && !ev_rel_n && !is_repeat) begin
      held_vld_p0 <= 1'b1;
    end else if (ev_fire && ev_rel_n && held_match) begin
      held_vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (ev_fire && !ev_rel_n) held_key_p0 <= key_n;
  end

  logic [17:0]     mem [DEPTH];
  logic [AW-1:0]   rd_p0, wr_p0, rd_nxt;
  logic [CW-1:0]   count_p0, count_nxt;
  logic [17:0]     entry_n, head_p0;
  logic            full, pop, push_do;

  assign entry_n   = {ev_ext_n, ev_rel_n, ps2_key_data, to_ascii(ps2_key_data, ev_ext_n)};
  assign ev_valid  = (count_p0 != '0);
  assign full      = (count_p0 == CW'(DEPTH));
  assign pop       = ev_valid && ev_ready;
  assign push_do   = push_req && (!full || pop);
  assign rd_nxt    = pop ? rd_p0 + 1'b1 : rd_p0;
  assign count_nxt = count_p0 + CW'(push_do) - CW'(pop);

  always_ff @(posedge clock) begin
    if (push_do) mem[wr_p0] <= entry_n;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_p0    <= '0;
      wr_p0    <= '0;
      count_p0 <= '0;
      overflow <= 1'b0;
    end else begin
      rd_p0    <= rd_nxt;
      count_p0 <= count_nxt;
      if (push_do) wr_p0 <= wr_p0 + 1'b1;
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (overflow_clr)        overflow <= 1'b0;
    end
  end

  // Stage 2: head register; a write landing on the new head slot is forwarded
  always_ff @(posedge clock) begin
    if (reset) begin
      head_p0 <= '0;
    end else if (count_nxt != '0) begin
      head_p0 <= (push_do && rd_nxt == wr_p0) ? entry_n : mem[rd_nxt];
    end
  end

  assign ev_ext     = head_p0[17];
  assign ev_release = head_p0[16];
  assign ev_code    = head_p0[15:8];
  assign ev_ascii   = head_p0[7:0];
  assign fifo_count = count_p0;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Directed bench for ps2_key_event_fifo: one instance with repeat suppression, one without.
module tb_ps2_key_event_fifo;

  logic       clock = 1'b0;
  logic       reset, reset_b;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed, ev_ready, ev_ready_b, overflow_clr;

  logic       ev_valid, ev_ext, ev_release, overflow;
  logic [7:0] ev_code, ev_ascii;
  logic [3:0] fifo_count;
  logic       ev_valid_b, ev_ext_b, ev_release_b, overflow_b;
  logic [7:0] ev_code_b, ev_ascii_b;
  logic [3:0] fifo_count_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ps2_key_event_fifo #(.DEPTH(8), .TIMEOUT_CYCLES(16), .SUPPRESS_REPEAT(1'b1)) u_a (
    .clock(clock), .reset(reset), .ps2_key_data(ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed), .ev_ready(ev_ready), .overflow_clr(overflow_clr),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext), .ev_release(ev_release),
    .ev_ascii(ev_ascii), .fifo_count(fifo_count), .overflow(overflow));

  ps2_key_event_fifo #(.DEPTH(8), .TIMEOUT_CYCLES(16), .SUPPRESS_REPEAT(1'b0)) u_b (
    .clock(clock), .reset(reset_b), .ps2_key_data(ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed), .ev_ready(ev_ready_b), .overflow_clr(overflow_clr),
    .ev_valid(ev_valid_b), .ev_code(ev_code_b), .ev_ext(ev_ext_b), .ev_release(ev_release_b),
    .ev_ascii(ev_ascii_b), .fifo_count(fifo_count_b), .overflow(overflow_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {valid, ext, release, code, ascii} of instance A's head.
  task automatic check_ev(input string tag, input logic [7:0] code, input logic ext,
                          input logic rel, input logic [7:0] ascii);
    check(tag, {13'd0, ev_valid, ev_ext, ev_release, ev_code, ev_ascii},
          {13'd0, 1'b1, ext, rel, code, ascii});
  endtask

  task automatic strobe(input logic [7:0] b);
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    @(posedge clock); #1;
    ps2_key_pressed = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic pop;
    ev_ready = 1'b1;
    @(posedge clock); #1;
    ev_ready = 1'b0;
  endtask

  logic [7:0] fill_codes [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
  logic [7:0] drain_codes [8] = '{8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h3B};
  logic [7:0] drain_ascii [8] = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h4A};

  initial begin
    reset = 1'b1; reset_b = 1'b1;
    ps2_key_data = 8'h00; ps2_key_pressed = 1'b0;
    ev_ready = 1'b0; ev_ready_b = 1'b0; overflow_clr = 1'b0;
    idle(1);
    strobe(8'h1C);
    idle(1);
    reset = 1'b0;
    check("rst_valid", ev_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_head", {ev_ext, ev_release, ev_code, ev_ascii}, 0);
    idle(1);
    check("rst_strobe_ignored", {ev_valid, fifo_count}, 0);

    // Basic make event and pop
    strobe(8'h1C);
    check_ev("make_A", 8'h1C, 0, 0, 8'h41);
    check("make_A_count", fifo_count, 1);
    pop();
    check("pop_empty", {ev_valid, fifo_count}, 0);
    pop();
    check("pop_when_empty", {ev_valid, fifo_count}, 0);

    // Break with idle gap, lone F0, ignored byte
    strobe(8'hF0);
    idle(10);
    strobe(8'h1C);
    check_ev("break_A", 8'h1C, 0, 1, 8'h41);
    check("break_A_count", fifo_count, 1);
    pop();
    strobe(8'hF0);
    idle(3);
    check("lone_F0", fifo_count, 0);
    strobe(8'hFA);
    idle(1);
    check("byte_FA", fifo_count, 0);

    // Extended events
    strobe(8'hE0); strobe(8'hF0); strobe(8'h75);
    check_ev("ext_break_75", 8'h75, 1, 1, 8'h00);
    check("ext_break_count", fifo_count, 1);
    pop();
    strobe(8'hE0); strobe(8'h5A);
    check_ev("ext_make_5A", 8'h5A, 1, 0, 8'h00);
    pop();

    // Repeat filter, both settings
    reset_b = 1'b0;
    strobe(8'h1C); strobe(8'h1C); strobe(8'h1C); strobe(8'hF0); strobe(8'h1C);
    check("rep_count", fifo_count, 2);
    check_ev("rep_first", 8'h1C, 0, 0, 8'h41);
    pop();
    check_ev("rep_second", 8'h1C, 0, 1, 8'h41);
    pop();
    check("rep_drained", fifo_count, 0);
    check("norep_count", fifo_count_b, 4);
    check("norep_head", {ev_valid_b, ev_release_b, ev_code_b}, {1'b1, 1'b0, 8'h1C});
    reset_b = 1'b1;

    // Fill past full, overflow behaviour, push+pop while full
    for (int i = 0; i < 9; i++) strobe(fill_codes[i]);
    check("full_count", fifo_count, 8);
    check("full_overflow", overflow, 1);
    overflow_clr = 1'b1; idle(1); overflow_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    overflow_clr = 1'b1;
    strobe(8'h42);
    overflow_clr = 1'b0;
    check("ovf_set_wins", overflow, 1);
    overflow_clr = 1'b1; idle(1); overflow_clr = 1'b0;
    check_ev("full_head", 8'h1C, 0, 0, 8'h41);
    ev_ready = 1'b1;
    strobe(8'h3B);
    ev_ready = 1'b0;
    check("pushpop_count", fifo_count, 8);
    check("pushpop_no_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      check_ev($sformatf("drain_%0d", i), drain_codes[i], 0, 0, drain_ascii[i]);
      pop();
    end
    check("drain_empty", {ev_valid, fifo_count}, 0);

    // Prefix timeout and reset mid-prefix
    strobe(8'hE0);
    idle(20);
    strobe(8'h16);
    check_ev("timeout_1", 8'h16, 0, 0, 8'h31);
    pop();
    strobe(8'h24);
    strobe(8'hF0);
    reset = 1'b1; idle(1); reset = 1'b0;
    check("reset_mid_count", fifo_count, 0);
    check("reset_mid_valid", ev_valid, 0);
    strobe(8'h1C);
    check_ev("after_reset_make", 8'h1C, 0, 0, 8'h41);
    pop();
    strobe(8'h24);
    check_ev("held_cleared_by_reset", 8'h24, 0, 0, 8'h45);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_fifo.md
Name: ps2_key_event_fifo

Overview:
Sits directly downstream of the PS/2 keyboard interface. It consumes the raw scan-code byte stream and its one-cycle "byte received" strobe. It collapses Set-2 prefix sequences (E0 = extended, F0 = break) into single key events, filters typematic repeats and maps common make codes to ASCII. Completed events are buffered in a FIFO for the LCD path and for the processor, which reads them through a valid/ready handshake.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64.
TIMEOUT_CYCLES, 50000000, cycles a prefix may wait for its next byte before it is discarded (1 s at 50 MHz).
SUPPRESS_REPEAT, 1, 1 = drop a make event if the same key is already held.

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
ps2_key_data  in  8  scan-code byte from the PS/2 interface
ps2_key_pressed  in  1  one-cycle strobe; ps2_key_data is valid in that cycle
ev_ready  in  1  consumer accepts the head event
overflow_clr  in  1  clears the overflow flag
ev_valid  out  1  FIFO not empty
ev_code  out  8  head event scan code (prefixes stripped)
ev_ext  out  1  head event was E0-prefixed
ev_release  out  1  head event is a break (F0)
ev_ascii  out  8  head event ASCII value; 00 if the code is unmapped or extended
fifo_count  out  clog2(DEPTH)+1  number of stored events
overflow  out  1  sticky; an event was dropped because the FIFO was full

Behaviour:
- Clock and reset:
  - All state updates on the rising edge of clock.
  - reset is sampled synchronously and overrides every other input.
- Reset values:
  - ev_valid=0, fifo_count=0, overflow=0.
  - ev_code, ev_ext, ev_release and ev_ascii are all 0.
  - Parser is in IDLE; held-key register is invalid; timeout counter is 0.
  - A strobe in the reset cycle is ignored.
- Parser FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen). It acts only in strobe cycles, except for the timeout rule.
  - Byte E0 in IDLE -> EXT. Byte E0 in any other state -> EXT; the prior prefix is lost.
  - Byte F0 from IDLE -> BRK. F0 from EXT -> EXT_BRK. F0 from BRK or EXT_BRK -> no state change.
  - Bytes 00, AA, E1, EE, FA, FE, FF -> dropped, no event; state returns to IDLE.
  - Any other byte -> one event {code=byte, ext, release} built from the current state; state returns to IDLE.
- Timeout:
  - The counter runs while the FSM is not in IDLE and clears on every strobe.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE and no event is produced.
- Repeat filter (SUPPRESS_REPEAT=1):
  - Held register stores {ext,code} of the last make event.
  - A make event equal to the held key while held is valid -> dropped.
  - Any other make event -> pushed, and it becomes the held key.
  - A break event equal to the held key invalidates the held register.
  - Break events are always pushed.
  - With SUPPRESS_REPEAT=0 every make event is pushed.
- ASCII map (non-extended events only, make and break alike):
  - Letters map to uppercase:
    - A 1C, B 32, C 21, D 23, E 24, F 2B, G 34
    - H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31
    - O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C
    - V 2A, W 1D, X 22, Y 35, Z 1A
  - Digits:
    - 0 45, 1 16, 2 1E, 3 26, 4 25
    - 5 2E, 6 36, 7 3D, 8 3E, 9 46
  - Space 29 -> 20; Enter 5A -> 0D; all other codes -> 00.
  - ASCII is computed at push time and stored in the entry (18 bits per entry).
- FIFO:
  - First-word fall-through; ev_* outputs reflect the head entry whenever ev_valid=1.
  - Pop happens when ev_valid && ev_ready.
  - Latency: an event-producing strobe at cycle N gives ev_valid=1 at cycle N+1 if the FIFO was empty.
  - Pointers wrap modulo DEPTH.
  - ev_valid=0 with ev_ready=1 -> no effect.
- Full and overflow:
  - Push while full with no pop in the same cycle -> the event is dropped; overflow is set.
  - Push and pop together while full -> both occur; fifo_count unchanged; no overflow.
  - Push and pop together while empty -> the event is stored, not bypassed; it appears at N+1.
  - overflow_clr clears overflow; if it coincides with a new drop, the set wins.
- ev_code etc. hold their last value when the FIFO is empty. The bench must not check them while ev_valid=0.

Test Plan:
1. Strobe 1C with ev_ready=0 -> next cycle: ev_valid=1, ev_code=1C, ev_ext=0, ev_release=0, ev_ascii=41, fifo_count=1. Then ev_ready=1 for one cycle -> ev_valid=0, fifo_count=0.
2. Strobe F0, then 10 idle cycles, then strobe 1C -> exactly one event: release=1, ascii=41. A lone F0 produces nothing. A strobe of FA produces nothing.
3. Strobe E0, F0, 75 -> one event: code=75, ext=1, release=1, ascii=00. Strobe E0, 5A -> one event: ext=1, ascii=00.
4. Strobe 1C, 1C, 1C, F0, 1C with SUPPRESS_REPEAT=1 -> exactly two events: (1C make, ascii=41) then (1C break). Same stimulus with SUPPRESS_REPEAT=0 -> four events.
5. DEPTH=8, ev_ready=0, strobe nine distinct letters -> fifo_count=8, overflow=1. Drain returns the first eight in order. Push and pop in the same cycle while full keeps count=8 and sets no new overflow. overflow_clr -> overflow=0.
6. TIMEOUT_CYCLES=16: strobe E0, wait 20 cycles, strobe 16 -> event with ext=0, ascii=31. Assert reset mid-prefix (after F0), then strobe 1C -> make event with release=0, and fifo_count was 0 after reset.
